// File: rtl/mem_access_ctrl_if.sv
// Data-cache request/response bus between the MEM-stage access controller and the cache.
// The controller is the master: it issues requests and waits for a one-cycle response pulse.
interface mem_access_ctrl_if;
   logic [15:0] dmem_address;
   logic        dmem_read;
   logic        dmem_write;
   logic [1:0]  dmem_byte_enable;
   logic [15:0] dmem_wdata;
   logic        dmem_resp;
   logic [15:0] dmem_rdata;

   modport master (
      output dmem_address,
      output dmem_read,
      output dmem_write,
      output dmem_byte_enable,
      output dmem_wdata,
      input  dmem_resp,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_address,
      input  dmem_read,
      input  dmem_write,
      input  dmem_byte_enable,
      input  dmem_wdata,
      output dmem_resp,
      output dmem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3b MEM-stage data-memory initiator: runs the plain, byte or indirect (LDI/STI) accesses
// of the current instruction against the data cache and stalls the pipeline until they finish.
module mem_access_ctrl (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_valid,
   input  logic                     mem_read_op,
   input  logic                     mem_write_op,
   input  logic                     mem_byte_op,
   input  logic                     mem_indirect,
   input  logic [15:0]              mem_address,
   input  logic [15:0]              mem_wdata,
   mem_access_ctrl_if.master        dmem,
   output logic [15:0]              mem_rdata,
   output logic                     mem_stall,
   output logic                     wb_load
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC1 = 2'd1;
   localparam logic [1:0] ACC2 = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state_q, state_d;
   logic        addr_lsb_q, addr_lsb_d;
   logic [15:0] wdata_q, wdata_d;
   logic        rd_q, rd_d;
   logic        byte_q, byte_d;
   logic        ind_q, ind_d;
   logic [14:0] ptr_q, ptr_d;
   logic [15:0] dmem_address_q, dmem_address_d;
   logic        dmem_read_q, dmem_read_d;
   logic        dmem_write_q, dmem_write_d;
   logic [1:0]  dmem_be_q, dmem_be_d;
   logic [15:0] dmem_wdata_q, dmem_wdata_d;
   logic [15:0] mem_rdata_q, mem_rdata_d;

   logic        is_mem;
   logic [7:0]  byte_lane;

   assign is_mem    = mem_valid & (mem_read_op | mem_write_op);
   assign byte_lane = addr_lsb_q ? dmem.dmem_rdata[15:8] : dmem.dmem_rdata[7:0];

   // Requests are registered: the first one is set up while accepting in IDLE, and the
   // indirect second access gets its own setup cycle in ACC2 after the first strobe drops.
   always_comb begin
      state_d        = state_q;
      addr_lsb_d     = addr_lsb_q;
      wdata_d        = wdata_q;
      rd_d           = rd_q;
      byte_d         = byte_q;
      ind_d          = ind_q;
      ptr_d          = ptr_q;
      dmem_address_d = dmem_address_q;
      dmem_read_d    = dmem_read_q;
      dmem_write_d   = dmem_write_q;
      dmem_be_d      = dmem_be_q;
      dmem_wdata_d   = dmem_wdata_q;
      mem_rdata_d    = mem_rdata_q;

      case (state_q)
         IDLE: begin
            if (is_mem) begin
               addr_lsb_d     = mem_address[0];
               wdata_d        = mem_wdata;
               rd_d           = mem_read_op;
               byte_d         = mem_byte_op & ~mem_indirect;
               ind_d          = mem_indirect;
               dmem_address_d = {mem_address[15:1], 1'b0};
               if (mem_indirect || mem_read_op) begin
                  dmem_read_d  = 1'b1;
                  dmem_write_d = 1'b0;
                  dmem_be_d    = 2'b00;
               end else begin
                  dmem_read_d  = 1'b0;
                  dmem_write_d = 1'b1;
                  if (mem_byte_op) begin
                     dmem_be_d    = mem_address[0] ? 2'b10 : 2'b01;
                     dmem_wdata_d = {mem_wdata[7:0], mem_wdata[7:0]};
                  end else begin
                     dmem_be_d    = 2'b11;
                     dmem_wdata_d = mem_wdata;
                  end
               end
               state_d = ACC1;
            end
         end
         ACC1: begin
            if (dmem.dmem_resp) begin
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               if (ind_q) begin
                  ptr_d   = dmem.dmem_rdata[15:1];
                  state_d = ACC2;
               end else begin
                  if (rd_q)
                     mem_rdata_d = byte_q ? {{8{byte_lane[7]}}, byte_lane} : dmem.dmem_rdata;
                  state_d = DONE;
               end
            end
         end
         ACC2: begin
            if (!dmem_read_q && !dmem_write_q) begin
               dmem_address_d = {ptr_q, 1'b0};
               dmem_read_d    = rd_q;
               dmem_write_d   = ~rd_q;
               dmem_be_d      = rd_q ? 2'b00 : 2'b11;
               dmem_wdata_d   = wdata_q;
            end else if (dmem.dmem_resp) begin
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               if (rd_q)
                  mem_rdata_d = dmem.dmem_rdata;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         addr_lsb_q     <= 1'b0;
         wdata_q        <= 16'h0000;
         rd_q           <= 1'b0;
         byte_q         <= 1'b0;
         ind_q          <= 1'b0;
         ptr_q          <= 15'h0000;
         dmem_address_q <= 16'h0000;
         dmem_read_q    <= 1'b0;
         dmem_write_q   <= 1'b0;
         dmem_be_q      <= 2'b00;
         dmem_wdata_q   <= 16'h0000;
         mem_rdata_q    <= 16'h0000;
      end else begin
         state_q        <= state_d;
         addr_lsb_q     <= addr_lsb_d;
         wdata_q        <= wdata_d;
         rd_q           <= rd_d;
         byte_q         <= byte_d;
         ind_q          <= ind_d;
         ptr_q          <= ptr_d;
         dmem_address_q <= dmem_address_d;
         dmem_read_q    <= dmem_read_d;
         dmem_write_q   <= dmem_write_d;
         dmem_be_q      <= dmem_be_d;
         dmem_wdata_q   <= dmem_wdata_d;
         mem_rdata_q    <= mem_rdata_d;
      end
   end

   assign dmem.dmem_address     = dmem_address_q;
   assign dmem.dmem_read        = dmem_read_q;
   assign dmem.dmem_write       = dmem_write_q;
   assign dmem.dmem_byte_enable = dmem_be_q;
   assign dmem.dmem_wdata       = dmem_wdata_q;
   assign mem_rdata             = mem_rdata_q;
   assign mem_stall             = is_mem & (state_q != DONE);
   assign wb_load               = ~mem_stall;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Data-memory initiator for the MEM stage of the LC-3b pipeline.
- Takes the MEM-stage instruction's control bits, address and store data, and drives the data-cache request/response handshake.
- Performs the one or two accesses each instruction needs: plain, byte, or indirect (LDI/STI).
- Stalls the pipeline while accesses are in flight. Produces the load data and the load enable consumed by the MEM/WB pipeline register.

Parameters:
- none (datapath fixed at 16 bits, lc3b_word)

Ports:
- clk  input  1  pipeline clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- mem_valid  input  1  MEM-stage instruction is valid
- mem_read_op  input  1  instruction reads memory (LDR/LDB/LDI)
- mem_write_op  input  1  instruction writes memory (STR/STB/STI)
- mem_byte_op  input  1  byte access (LDB/STB)
- mem_indirect  input  1  indirect access (LDI/STI)
- mem_address  input  16  effective address from EX
- mem_wdata  input  16  store data (SR value)
- dmem_resp  input  1  cache response, one-cycle pulse per completed access
- dmem_rdata  input  16  cache read data, valid with dmem_resp
- dmem_address  output  16  cache address
- dmem_read  output  1  cache read request
- dmem_write  output  1  cache write request
- dmem_byte_enable  output  2  write byte lanes
- dmem_wdata  output  16  cache write data
- mem_rdata  output  16  load result to the MEM/WB register
- mem_stall  output  1  freeze IF..MEM and hold the MEM/WB load low
- wb_load  output  1  MEM/WB register load enable

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). It is sampled only on the rising edge of clk.
- Reset state: state=IDLE; dmem_read=0, dmem_write=0, dmem_byte_enable=00, dmem_address=0, dmem_wdata=0, mem_rdata=0.
- Definition: is_mem = mem_valid & (mem_read_op | mem_write_op).
- Comb outputs:
  - mem_stall = is_mem & (state != DONE).
  - wb_load = ~mem_stall.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE:
  - If is_mem, capture address, wdata and op bits into internal registers, then go to ACC1.
  - If not is_mem, stay in IDLE. Non-memory instructions pass with zero added latency (mem_stall=0).
- ACC1 (first access):
  - Indirect: word read at {addr[15:1],0}. On dmem_resp, capture dmem_rdata as the pointer and go to ACC2.
  - Word read: on dmem_resp, mem_rdata <= dmem_rdata, then go to DONE.
  - Byte read: on dmem_resp, mem_rdata <= sign-extended byte, then go to DONE. Byte is dmem_rdata[15:8] if addr[0]=1, else dmem_rdata[7:0].
  - Word write: byte_enable=11, dmem_wdata=wdata. On dmem_resp, go to DONE.
  - Byte write: byte_enable = addr[0] ? 10 : 01, dmem_wdata = {wdata[7:0], wdata[7:0]}. On dmem_resp, go to DONE.
- ACC2 (second indirect access):
  - Address is {pointer[15:1],0}.
  - Read (LDI): word read; on dmem_resp, mem_rdata <= dmem_rdata.
  - Write (STI): word write, byte_enable=11.
  - Go to DONE on dmem_resp.
  - mem_byte_op is ignored when mem_indirect=1.
- DONE:
  - Exactly one cycle. mem_stall=0 and wb_load=1, so the pipeline advances at the end of this cycle.
  - Next state is IDLE.
- Request strobes:
  - dmem_read/dmem_write are asserted from the cycle after acceptance. They stay constant (address, data, enables stable) until the cycle dmem_resp is sampled high.
  - They deassert in the following cycle.
  - Never both high.
- Word addresses always drive bit 0 = 0.
- Latency: minimum 3 cycles (single access) or 5 cycles (indirect) from is_mem first seen to wb_load=1, with dmem_resp on the first request cycle.
- mem_read_op & mem_write_op both 1: treated as a read; the write is ignored.
- dmem_resp in IDLE or DONE: ignored.
- mem_rdata holds its last value between loads. It is not updated by stores.
- Reset mid-operation: next cycle is IDLE, strobes are low and mem_rdata=0. A late dmem_resp from the aborted access is ignored.
- mem_valid dropping while in ACC1/ACC2: the access still completes; captured registers are used.

Test Plan:
- LDR at 0x3002, cache returns 0xBEEF after 2 wait cycles -> dmem_read high 3 cycles at address 0x3002, mem_rdata=0xBEEF, wb_load high exactly one cycle (DONE), mem_stall high before that.
- LDB at 0x3003, rdata=0x80AA -> mem_rdata=0xFF80. LDB at 0x3002 -> mem_rdata=0xFFAA. STB at 0x3001 with wdata 0x1234 -> byte_enable=10, dmem_wdata=0x3434, dmem_address=0x3000.
- LDI at 0x4000 (pointer 0x5000, data 0x0042) -> two reads, at 0x4000 then 0x5000, mem_rdata=0x0042. STI with wdata 0x7777 -> read 0x4000, then write 0x7777 to 0x5000 with byte_enable=11.
- ADD (no mem op) behind LDR, resp immediate -> ADD sees mem_stall=0 and is not delayed. LDR total latency 3 cycles.
- reset asserted in ACC1 mid-wait -> next cycle all outputs at reset values; following dmem_resp ignored; fresh STR afterwards completes normally.
- read_op and write_op both set, with a spurious dmem_resp in IDLE -> only a read is issued; state stays IDLE on the spurious resp.
